sfp_link_sequencer: RTL and testbench

SFP_LINK_SEQUENCER -- requirements
Module: sfp_link_sequencer

---
 rtl/sfp_link_sequencer.sv | 122 ++++++++++++
 tb/tb_sfp_link_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sfp_link_sequencer.sv
// sfp_link_sequencer: SFP/GTY bring-up sequencer with timeouts, retry limit, LOS debounce and lane select.
module sfp_link_sequencer #(
   parameter int HOLD_CYCLES     = 1000,
   parameter int TIMEOUT_CYCLES  = 1250000,
   parameter int DEBOUNCE_CYCLES = 125,
   parameter int MAX_RETRY       = 3,
   parameter int DEFAULT_LANE    = 2
) (
   input  logic       aclk,
   input  logic       aresetn,
   input  logic [1:0] lane_sel_in,
   input  logic       lane_sel_load,
   input  logic       pll_lock,
   input  logic [3:0] tx_reset_done,
   input  logic [3:0] rx_reset_done,
   input  logic       sfp_los,
   input  logic       sfp_mod_abs,
   output logic [1:0] lane_sel,
   output logic       gt_reset,
   output logic       sfp_tx_disable,
   output logic       link_up,
   output logic       fault,
   output logic [3:0] retry_cnt,
   output logic [2:0] state
);
   localparam int CW = 24;
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_DISABLE = 3'd1, S_RESET_GT = 3'd2, S_WAIT_PLL = 3'd3,
      S_WAIT_DONE = 3'd4, S_UP = 3'd5, S_FAULT = 3'd6
   } state_e;
   state_e          state_q, state_d, to_state;
   logic [CW-1:0]   cnt_q, cnt_d, los_q, los_d, los_inc;
   logic [3:0]      retry_q, retry_d, retry_inc;
   logic [1:0]      lane_q, lane_d;
   logic            gt_q, txd_q, link_q, fault_q;
   logic            load_ok, hold_done, timeout, lane_done, los_exp;
   always_comb begin
      load_ok   = lane_sel_load && (state_q == S_IDLE || state_q == S_UP || state_q == S_FAULT);
      hold_done = cnt_q == CW'(HOLD_CYCLES - 1);
      timeout   = cnt_q == CW'(TIMEOUT_CYCLES - 1);
      lane_done = tx_reset_done[lane_q] && rx_reset_done[lane_q];
      los_inc   = los_q + CW'(1);
      los_exp   = sfp_los && los_inc == CW'(DEBOUNCE_CYCLES);
      retry_inc = retry_q + 4'd1;
      to_state  = retry_inc == 4'(MAX_RETRY) ? S_FAULT : S_DISABLE;
      state_d   = state_q;
      retry_d   = retry_q;
      lane_d    = load_ok ? lane_sel_in : lane_q;
      if (sfp_mod_abs) begin
         state_d = S_IDLE;
         retry_d = '0;
      end else begin
         case (state_q)
            S_IDLE:      state_d = S_DISABLE;
            S_DISABLE:   state_d = hold_done ? S_RESET_GT : S_DISABLE;
            S_RESET_GT:  state_d = hold_done ? S_WAIT_PLL : S_RESET_GT;
            S_WAIT_PLL:
               if (pll_lock) state_d = S_WAIT_DONE;
               else if (timeout) begin
                  state_d = to_state;
                  retry_d = retry_inc;
               end
            S_WAIT_DONE:
               if (!pll_lock) state_d = S_WAIT_PLL;
               else if (lane_done) state_d = S_UP;
               else if (timeout) begin
                  state_d = to_state;
                  retry_d = retry_inc;
               end
            S_UP:
               if (load_ok) begin
                  state_d = S_DISABLE;
                  retry_d = '0;
               end else if (!pll_lock) begin
                  state_d = S_DISABLE;
                  retry_d = retry_inc;
               end else if (los_exp) state_d = S_DISABLE;
            S_FAULT:
               if (load_ok) begin
                  state_d = S_DISABLE;
                  retry_d = '0;
               end
            default:     state_d = S_IDLE;
         endcase
      end
      // UP always holds a zero retry count, however it was entered
      if (state_d == S_UP) retry_d = '0;
      cnt_d = state_d != state_q ? '0 : cnt_q + CW'(1);
      los_d = state_q == S_UP && state_d == S_UP && sfp_los ? los_inc : '0;
   end
   // Status outputs are registered from the next state so they track state exactly
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         los_q   <= '0;
         retry_q <= '0;
         lane_q  <= 2'(DEFAULT_LANE);
         gt_q    <= 1'b1;
         txd_q   <= 1'b1;
         link_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         los_q   <= los_d;
         retry_q <= retry_d;
         lane_q  <= lane_d;
         gt_q    <= state_d == S_IDLE || state_d == S_RESET_GT || state_d == S_FAULT;
         txd_q   <= state_d != S_UP;
         link_q  <= state_d == S_UP;
         fault_q <= state_d == S_FAULT;
      end
   end
   assign state          = state_q;
   assign lane_sel       = lane_q;
   assign retry_cnt      = retry_q;
   assign gt_reset       = gt_q;
   assign sfp_tx_disable = txd_q;
   assign link_up        = link_q;
   assign fault          = fault_q;
endmodule

// File: tb/tb_sfp_link_sequencer.sv
// tb_sfp_link_sequencer: directed vector table, corner sequences and random run against a cycle model.
module tb_sfp_link_sequencer;
   localparam int HOLD = 4, TO = 16, DEB = 3, MAXR = 3;
   logic       aclk = 1'b0, aresetn = 1'b1;
   logic [1:0] lane_sel_in = '0;
   logic       lane_sel_load = 1'b0, pll_lock = 1'b0, sfp_los = 1'b0, sfp_mod_abs = 1'b0;
   logic [3:0] tx_reset_done = '0, rx_reset_done = '0;
   logic [1:0] lane_sel;
   logic       gt_reset, sfp_tx_disable, link_up, fault;
   logic [3:0] retry_cnt;
   logic [2:0] state;
   int checks = 0, failures = 0;
   int ms, mlane, mretry, mage, mrun;

   always #5 aclk = ~aclk;

   sfp_link_sequencer #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO), .DEBOUNCE_CYCLES(DEB),
                        .MAX_RETRY(MAXR), .DEFAULT_LANE(2)) dut (
      .aclk(aclk), .aresetn(aresetn), .lane_sel_in(lane_sel_in), .lane_sel_load(lane_sel_load),
      .pll_lock(pll_lock), .tx_reset_done(tx_reset_done), .rx_reset_done(rx_reset_done),
      .sfp_los(sfp_los), .sfp_mod_abs(sfp_mod_abs), .lane_sel(lane_sel), .gt_reset(gt_reset),
      .sfp_tx_disable(sfp_tx_disable), .link_up(link_up), .fault(fault),
      .retry_cnt(retry_cnt), .state(state));

   task automatic chk(input string name, input logic [15:0] act, input int exp);
      checks++;
      if (act !== 16'(exp)) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      ms = 0; mlane = 2; mretry = 0; mage = 0; mrun = 0;
   endfunction

   // Reference: state number, cycles spent in it, consecutive-LOS run and retry tally
   function automatic void model_step();
      int ns = ms, age = mage + 1;
      bit to = 0;
      if (lane_sel_load && (ms == 0 || ms == 5 || ms == 6)) mlane = int'(lane_sel_in);
      if (sfp_mod_abs) begin
         ns = 0; mretry = 0;
      end else case (ms)
         0: ns = 1;
         1: if (age == HOLD) ns = 2;
         2: if (age == HOLD) ns = 3;
         3: if (pll_lock) ns = 4; else if (age == TO) to = 1;
         4: if (!pll_lock) ns = 3;
            else if (tx_reset_done[mlane] && rx_reset_done[mlane]) ns = 5;
            else if (age == TO) to = 1;
         5: begin
            mrun = sfp_los ? mrun + 1 : 0;
            if (lane_sel_load) begin ns = 1; mretry = 0; end
            else if (!pll_lock) begin ns = 1; mretry++; end
            else if (mrun == DEB) ns = 1;
         end
         6: if (lane_sel_load) begin ns = 1; mretry = 0; end
         default: ns = 0;
      endcase
      if (to) begin
         mretry++;
         ns = mretry == MAXR ? 6 : 1;
      end
      if (ns == 5) mretry = 0;
      else mrun = 0;
      mage = ns != ms ? 0 : age;
      ms = ns;
   endfunction

   task automatic check_model();
      int flags;
      flags = (ms == 5 ? 8 : 0) + (ms == 6 ? 4 : 0) + ((ms == 0 || ms == 2 || ms == 6) ? 2 : 0) + (ms != 5 ? 1 : 0);
      chk("model_state", 16'(state), ms);
      chk("model_lane", 16'(lane_sel), mlane);
      chk("model_retry", 16'(retry_cnt), mretry);
      chk("model_flags{link,fault,gt,txdis}", 16'({link_up, fault, gt_reset, sfp_tx_disable}), flags);
   endtask

   task automatic tick();
      @(posedge aclk);
      model_step();
      @(negedge aclk);
      check_model();
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      #1;
      model_reset();
      check_model();
      @(negedge aclk);
      aresetn = 1'b1;
   endtask

   typedef struct {
      bit rst; bit abs; bit pll; logic [3:0] done; bit los; bit load; logic [1:0] lin;
      int n; int st; int lane; int retry;
   } vec_t;
   vec_t tbl[$];

   initial begin
      int pll_pct;
      //           rst abs pll done    los ld lin  n  st ln rt
      tbl.push_back('{1, 0, 0, 4'h0, 0, 0, 0,  1, 1, 2, 0});   // bring-up
      tbl.push_back('{0, 0, 0, 4'h0, 0, 0, 0,  4, 2, 2, 0});
      tbl.push_back('{0, 0, 0, 4'h0, 0, 0, 0,  4, 3, 2, 0});
      tbl.push_back('{0, 0, 0, 4'h0, 0, 0, 0,  5, 3, 2, 0});
      tbl.push_back('{0, 0, 1, 4'h4, 0, 0, 0,  1, 4, 2, 0});
      tbl.push_back('{0, 0, 1, 4'h4, 0, 0, 0,  1, 5, 2, 0});
      tbl.push_back('{0, 0, 1, 4'h4, 1, 0, 0,  2, 5, 2, 0});   // LOS debounce
      tbl.push_back('{0, 0, 1, 4'h4, 0, 0, 0,  1, 5, 2, 0});
      tbl.push_back('{0, 0, 1, 4'h4, 1, 0, 0,  2, 5, 2, 0});
      tbl.push_back('{0, 0, 1, 4'h4, 0, 0, 0,  1, 5, 2, 0});
      tbl.push_back('{0, 0, 1, 4'h4, 1, 0, 0,  3, 1, 2, 0});
      tbl.push_back('{0, 0, 1, 4'h4, 0, 0, 0,  8, 3, 2, 0});
      tbl.push_back('{0, 0, 1, 4'h4, 0, 0, 0,  1, 4, 2, 0});
      tbl.push_back('{0, 0, 1, 4'h4, 0, 0, 0,  1, 5, 2, 0});
      tbl.push_back('{1, 0, 0, 4'h0, 0, 0, 0,  9, 3, 2, 0});   // retry to FAULT
      tbl.push_back('{0, 0, 0, 4'h0, 0, 0, 0, 15, 3, 2, 0});
      tbl.push_back('{0, 0, 0, 4'h0, 0, 0, 0,  1, 1, 2, 1});
      tbl.push_back('{0, 0, 0, 4'h0, 0, 0, 0,  8, 3, 2, 1});
      tbl.push_back('{0, 0, 0, 4'h0, 0, 0, 0, 16, 1, 2, 2});
      tbl.push_back('{0, 0, 0, 4'h0, 0, 0, 0,  8, 3, 2, 2});
      tbl.push_back('{0, 0, 0, 4'h0, 0, 0, 0, 16, 6, 2, 3});
      tbl.push_back('{0, 0, 0, 4'h0, 0, 0, 0,  5, 6, 2, 3});
      tbl.push_back('{0, 0, 0, 4'h0, 0, 1, 1,  1, 1, 1, 0});
      tbl.push_back('{1, 0, 1, 4'h4, 0, 1, 0,  1, 1, 0, 0});   // lane mismatch
      tbl.push_back('{0, 0, 1, 4'h4, 0, 0, 0,  8, 3, 0, 0});
      tbl.push_back('{0, 0, 1, 4'h4, 0, 0, 0,  1, 4, 0, 0});
      tbl.push_back('{0, 0, 1, 4'h4, 0, 0, 0, 15, 4, 0, 0});
      tbl.push_back('{0, 0, 1, 4'h4, 0, 0, 0,  1, 1, 0, 1});
      tbl.push_back('{0, 0, 1, 4'h4, 0, 1, 3,  1, 1, 0, 1});   // load ignored in DISABLE
      @(negedge aclk);
      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         sfp_mod_abs = tbl[i].abs; pll_lock = tbl[i].pll;
         tx_reset_done = tbl[i].done; rx_reset_done = tbl[i].done;
         sfp_los = tbl[i].los; lane_sel_load = tbl[i].load; lane_sel_in = tbl[i].lin;
         repeat (tbl[i].n) tick();
         lane_sel_load = 1'b0;
         chk($sformatf("vec%0d_state", i), 16'(state), tbl[i].st);
         chk($sformatf("vec%0d_lane", i), 16'(lane_sel), tbl[i].lane);
         chk($sformatf("vec%0d_retry", i), 16'(retry_cnt), tbl[i].retry);
      end
      // mod_abs during RESET_GT, pll drop in WAIT_DONE, async reset in WAIT_DONE
      do_reset();
      sfp_mod_abs = 0; pll_lock = 1; tx_reset_done = '0; rx_reset_done = '0; sfp_los = 0;
      repeat (5) tick();
      chk("prio_reset_gt", 16'(state), 2);
      sfp_mod_abs = 1;
      tick();
      chk("prio_abs_idle", 16'(state), 0);
      chk("prio_abs_gt", 16'(gt_reset), 1);
      sfp_mod_abs = 0;
      repeat (10) tick();
      chk("pll_drop_pre", 16'(state), 4);
      pll_lock = 0;
      tick();
      chk("pll_drop_state", 16'(state), 3);
      chk("pll_drop_retry", 16'(retry_cnt), 0);
      pll_lock = 1;
      tick();
      chk("async_pre", 16'(state), 4);
      #2 aresetn = 1'b0;
      #1;
      chk("async_state", 16'(state), 0);
      chk("async_lane", 16'(lane_sel), 2);
      chk("async_flags", 16'({link_up, fault, gt_reset, sfp_tx_disable}), 3);
      model_reset();
      @(negedge aclk);
      aresetn = 1'b1;
      // lane load coinciding with LOS debounce expiry in UP
      tx_reset_done = '1; rx_reset_done = '1;
      repeat (11) tick();
      chk("coinc_up", 16'(state), 5);
      chk("coinc_link", 16'(link_up), 1);
      chk("coinc_txdis", 16'(sfp_tx_disable), 0);
      sfp_los = 1;
      repeat (2) tick();
      lane_sel_load = 1; lane_sel_in = 3;
      tick();
      lane_sel_load = 0;
      chk("coinc_state", 16'(state), 1);
      chk("coinc_lane", 16'(lane_sel), 3);
      tick();
      chk("coinc_once", 16'(state), 1);
      // random run against the model
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         pll_pct = (c / 400) % 2 == 0 ? 93 : 6;
         sfp_mod_abs   = $urandom_range(0, 199) < 3;
         pll_lock      = $urandom_range(0, 99) < pll_pct;
         tx_reset_done = 4'($urandom);
         rx_reset_done = 4'($urandom);
         sfp_los       = $urandom_range(0, 99) < 30;
         lane_sel_load = $urandom_range(0, 99) < 3;
         lane_sel_in   = 2'($urandom);
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
